uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
- Shares the single UART transmitter between two byte-stream sources: the case-converted echo stream (source 0) and a status/message generator (source 1).
- Arbitration is round-robin and message-based. A granted source keeps the transmitter until it sends a byte flagged last, or until it stalls past a timeout.
- Sits between the sources and the uart_tx instance. Drives the transmitter's data/valid inputs and consumes its ready output.

Parameters:
- TIMEOUT, 25000, clock cycles a locked source may leave its valid low mid-message before the lock is revoked (about 20 bit times at 12 MHz / 9600 baud); legal range 2..65535.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous assert, active-low
- s0_data  in  8  source 0 byte
- s0_valid  in  1  source 0 byte available
- s0_last  in  1  source 0 byte ends its message
- s0_ready  out  1  source 0 byte accepted this cycle when high together with s0_valid
- s1_data  in  8  source 1 byte
- s1_valid  in  1  source 1 byte available
- s1_last  in  1  source 1 byte ends its message
- s1_ready  out  1  source 1 handshake
- utx_data  out  8  byte to transmitter
- utx_valid  out  1  utx_data valid
- utx_ready  in  1  transmitter accepts; transfer when utx_valid && utx_ready
- grant  out  2  one-hot current owner; 00 when idle
- timeout_pulse  out  1  one-cycle pulse when a lock is revoked by timeout

Behaviour:
- Reset (async, rst_n low):
  - utx_data=0, utx_valid=0, s0_ready=s1_ready=0, grant=00, timeout_pulse=0.
  - State=IDLE, priority pointer=source 0, timeout counter=0.
  - A byte held in the output register is discarded; reset mid-message abandons the message.
- Output register:
  - One 8-bit holding register; utx_valid=1 means it is full.
  - utx_data is stable while utx_valid=1.
  - utx_valid clears on the cycle after utx_ready && utx_valid.
- Source ready:
  - sX_ready = (state==LOCK) && grant[X] && !utx_valid. This is a combinational decode of registered state.
  - A non-granted source always sees ready=0.
- IDLE:
  - grant=00.
  - Only one valid high: grant that source.
  - Both valid high: grant the source named by the priority pointer.
  - Next state LOCK. Arbitration costs 1 cycle; no byte is accepted in IDLE.
- LOCK:
  - On sX_valid && sX_ready: the byte loads into the output register, and utx_valid=1 on the next cycle (1-cycle latency). The timeout counter clears.
  - If the accepted byte has last=1, go to DRAIN.
  - Timeout counter increments each cycle that utx_valid=0 and the granted source's valid=0.
  - When the counter reaches TIMEOUT-1 the lock is revoked: timeout_pulse=1 for one cycle, grant=00, pointer set to the other source, counter cleared, state IDLE.
  - The counter holds while utx_valid=1, so transmitter backpressure never causes a timeout.
- DRAIN:
  - Ready outputs are 0. Wait until the last byte transfers (utx_valid falls).
  - Then grant=00, pointer set to the other source, state IDLE.
  - No timeout applies in DRAIN.
- Fairness: after any release (last or timeout) the other source has priority. With both sources continuously requesting, messages alternate 0,1,0,1...
- Simultaneous events:
  - Acceptance and the timeout threshold in the same cycle: acceptance wins and the counter clears.
  - The owner's valid dropping while a byte is in flight is not a stall.
- Sources must hold data/valid/last stable until accepted; the arbiter does not check this.
- Byte order within a message is preserved. Bytes from two messages are never interleaved.

Test Plan:
- Single byte: s0 sends 0x41 with last=1, utx_ready=1 -> grant=01 one cycle after valid. utx_valid rises the cycle after s0 handshake with utx_data=0x41. grant=00 after transfer.
- Backpressure: s1 sends 3-byte message 0x4F,0x4B,0x0A; utx_ready low for 50 cycles after each byte -> utx_data sequence 0x4F,0x4B,0x0A each held stable. No timeout_pulse with TIMEOUT=8. grant=10 throughout.
- Contention: both request from reset with 2-byte messages (s0: 0x48,0x49; s1: 0x4F,0x4B) -> output order 0x48,0x49,0x4F,0x4B. Repeating both gives alternating message ownership.
- Timeout (TIMEOUT=8): s0 sends 0x41 with last=0 then drops valid; s1 requesting -> timeout_pulse exactly once, 8 cycles after the transfer completes. grant then goes 00 -> 10, and s1's byte is transmitted next.
- Reset mid-message: assert rst_n low while utx_valid=1 holding 0x55 -> utx_valid, ready outputs and grant drop immediately. After release, s1 requesting alone is granted and 0x55 is never sent.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin, message-locked arbiter sharing one UART transmitter
// between two byte-stream sources, with stall timeout on the locked source.
module uart_tx_arbiter #(
  parameter int TIMEOUT = 25000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] s0_data,
  input  logic       s0_valid,
  input  logic       s0_last,
  output logic       s0_ready,
  input  logic [7:0] s1_data,
  input  logic       s1_valid,
  input  logic       s1_last,
  output logic       s1_ready,
  output logic [7:0] utx_data,
  output logic       utx_valid,
  input  logic       utx_ready,
  output logic [1:0] grant,
  output logic       timeout_pulse
);

  localparam logic [1:0]  S_IDLE  = 2'd0;
  localparam logic [1:0]  S_LOCK  = 2'd1;
  localparam logic [1:0]  S_DRAIN = 2'd2;
  localparam logic [15:0] CNT_MAX = 16'(TIMEOUT - 1);

  logic [1:0]  state_q, state_d;
  logic [1:0]  grant_q, grant_d;
  logic        ptr_q, ptr_d;
  logic [15:0] cnt_q, cnt_d;
  logic [7:0]  data_q, data_d;
  logic        valid_q, valid_d;
  logic        pulse_q, pulse_d;

  logic        owner;
  logic        own_valid;
  logic        own_last;
  logic [7:0]  own_data;
  logic        accept;

  assign owner     = grant_q[1];
  assign s0_ready  = (state_q == S_LOCK) && grant_q[0] && !valid_q;
  assign s1_ready  = (state_q == S_LOCK) && grant_q[1] && !valid_q;
  assign own_valid = owner ? s1_valid : s0_valid;
  assign own_last  = owner ? s1_last  : s0_last;
  assign own_data  = owner ? s1_data  : s0_data;
  assign accept    = own_valid && (owner ? s1_ready : s0_ready);

  assign utx_data      = data_q;
  assign utx_valid     = valid_q;
  assign grant         = grant_q;
  assign timeout_pulse = pulse_q;

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    valid_d = valid_q;
    pulse_d = 1'b0;

    if (valid_q && utx_ready) begin
      valid_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (s0_valid || s1_valid) begin
          state_d = S_LOCK;
          cnt_d   = 16'd0;
          if (s0_valid && s1_valid) begin
            grant_d = ptr_q ? 2'b10 : 2'b01;
          end else begin
            grant_d = s1_valid ? 2'b10 : 2'b01;
          end
        end
      end
      S_LOCK: begin
        // A stall only counts while nothing is in flight, so backpressure never revokes.
        if (accept) begin
          data_d  = own_data;
          valid_d = 1'b1;
          cnt_d   = 16'd0;
          if (own_last) begin
            state_d = S_DRAIN;
          end
        end else if (!valid_q && !own_valid) begin
          if (cnt_q >= CNT_MAX) begin
            state_d = S_IDLE;
            grant_d = 2'b00;
            ptr_d   = !owner;
            cnt_d   = 16'd0;
            pulse_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
      end
      S_DRAIN: begin
        if (!valid_q) begin
          state_d = S_IDLE;
          grant_d = 2'b00;
          ptr_d   = !owner;
        end
      end
      default: begin
        state_d = S_IDLE;
        grant_d = 2'b00;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      grant_q <= 2'b00;
      ptr_q   <= 1'b0;
      cnt_q   <= 16'd0;
      data_q  <= 8'd0;
      valid_q <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      pulse_q <= pulse_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - directed self-checking bench for uart_tx_arbiter (TIMEOUT=8).
module tb_uart_tx_arbiter;

  logic       clk;
  logic       rst_n;
  logic [7:0] s0_data, s1_data;
  logic       s0_valid, s0_last, s0_ready;
  logic       s1_valid, s1_last, s1_ready;
  logic [7:0] utx_data;
  logic       utx_valid, utx_ready;
  logic [1:0] grant;
  logic       timeout_pulse;

  int vectors;
  int miscompares;
  int to_cnt;
  int to_base;
  logic [8:0] q0[$];
  logic [8:0] q1[$];

  uart_tx_arbiter #(.TIMEOUT(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .s0_data(s0_data), .s0_valid(s0_valid), .s0_last(s0_last), .s0_ready(s0_ready),
    .s1_data(s1_data), .s1_valid(s1_valid), .s1_last(s1_last), .s1_ready(s1_ready),
    .utx_data(utx_data), .utx_valid(utx_valid), .utx_ready(utx_ready),
    .grant(grant), .timeout_pulse(timeout_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (timeout_pulse === 1'b1) to_cnt++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    s0_valid = (q0.size() > 0);
    {s0_last, s0_data} = (q0.size() > 0) ? q0[0] : 9'd0;
    s1_valid = (q1.size() > 0);
    {s1_last, s1_data} = (q1.size() > 0) ? q1[0] : 9'd0;
  endtask

  // Advance one cycle; pop a source's head byte if it handshook at this edge.
  task automatic step();
    logic h0, h1;
    h0 = s0_valid && s0_ready;
    h1 = s1_valid && s1_ready;
    @(posedge clk);
    #1;
    if (h0) void'(q0.pop_front());
    if (h1) void'(q1.pop_front());
    drive();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    utx_ready = 1'b0;
    q0.delete();
    q1.delete();
    drive();
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic wait_valid(input string tag);
    int n;
    n = 0;
    while (utx_valid !== 1'b1 && n < 40) begin
      step();
      n++;
    end
    if (utx_valid !== 1'b1) chk({tag, "_wait"}, 32'(utx_valid), 32'd1);
  endtask

  task automatic expect_byte(input string tag, input logic [7:0] exp, input logic [1:0] exp_grant,
                             input int hold);
    logic stable;
    utx_ready = 1'b0;
    wait_valid(tag);
    chk({tag, "_data"}, 32'(utx_data), 32'(exp));
    chk({tag, "_grant"}, 32'(grant), 32'(exp_grant));
    stable = 1'b1;
    for (int i = 0; i < hold; i++) begin
      step();
      if (utx_valid !== 1'b1 || utx_data !== exp) stable = 1'b0;
    end
    if (hold > 0) chk({tag, "_stable"}, 32'(stable), 32'd1);
    utx_ready = 1'b1;
    step();
    utx_ready = 1'b0;
    chk({tag, "_xfer"}, 32'(utx_valid), 32'd0);
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    to_cnt = 0;
    do_reset();
    chk("rst_valid", 32'(utx_valid), 32'd0);
    chk("rst_data", 32'(utx_data), 32'd0);
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_ready", 32'({s0_ready, s1_ready}), 32'd0);
    chk("rst_pulse", 32'(timeout_pulse), 32'd0);

    // Single byte from source 0
    q0.push_back({1'b1, 8'h41});
    utx_ready = 1'b1;
    drive();
    chk("t1_idle_grant", 32'(grant), 32'd0);
    step();
    chk("t1_grant", 32'(grant), 32'b01);
    chk("t1_s0_ready", 32'(s0_ready), 32'd1);
    chk("t1_s1_ready", 32'(s1_ready), 32'd0);
    step();
    chk("t1_valid", 32'(utx_valid), 32'd1);
    chk("t1_data", 32'(utx_data), 32'h41);
    chk("t1_ready_busy", 32'(s0_ready), 32'd0);
    step();
    chk("t1_xfer", 32'(utx_valid), 32'd0);
    chk("t1_drain_grant", 32'(grant), 32'b01);
    step();
    chk("t1_release", 32'(grant), 32'd0);
    utx_ready = 1'b0;

    // Backpressure on a 3-byte source 1 message
    to_base = to_cnt;
    q1.push_back({1'b0, 8'h4F});
    q1.push_back({1'b0, 8'h4B});
    q1.push_back({1'b1, 8'h0A});
    drive();
    expect_byte("t2_b0", 8'h4F, 2'b10, 50);
    expect_byte("t2_b1", 8'h4B, 2'b10, 50);
    expect_byte("t2_b2", 8'h0A, 2'b10, 50);
    step();
    chk("t2_release", 32'(grant), 32'd0);
    chk("t2_no_timeout", 32'(to_cnt - to_base), 32'd0);

    // Contention from reset, then a second round to show alternation
    do_reset();
    q0.push_back({1'b0, 8'h48});
    q0.push_back({1'b1, 8'h49});
    q0.push_back({1'b0, 8'h50});
    q0.push_back({1'b1, 8'h51});
    q1.push_back({1'b0, 8'h4F});
    q1.push_back({1'b1, 8'h4B});
    q1.push_back({1'b0, 8'h52});
    q1.push_back({1'b1, 8'h53});
    drive();
    expect_byte("t3_m0a", 8'h48, 2'b01, 2);
    expect_byte("t3_m0b", 8'h49, 2'b01, 0);
    expect_byte("t3_m1a", 8'h4F, 2'b10, 0);
    expect_byte("t3_m1b", 8'h4B, 2'b10, 3);
    expect_byte("t3_m2a", 8'h50, 2'b01, 0);
    expect_byte("t3_m2b", 8'h51, 2'b01, 0);
    expect_byte("t3_m3a", 8'h52, 2'b10, 0);
    expect_byte("t3_m3b", 8'h53, 2'b10, 0);

    // Timeout: source 0 stalls mid-message while source 1 waits
    do_reset();
    to_base = to_cnt;
    q0.push_back({1'b0, 8'h41});
    drive();
    expect_byte("t4_b0", 8'h41, 2'b01, 0);
    q1.push_back({1'b1, 8'h5A});
    drive();
    for (int i = 0; i < 7; i++) step();
    chk("t4_early_pulse", 32'(to_cnt - to_base), 32'd0);
    chk("t4_still_locked", 32'(grant), 32'b01);
    step();
    chk("t4_pulse", 32'(timeout_pulse), 32'd1);
    chk("t4_revoked", 32'(grant), 32'd0);
    step();
    chk("t4_pulse_once", 32'(timeout_pulse), 32'd0);
    chk("t4_regrant", 32'(grant), 32'b10);
    expect_byte("t4_s1", 8'h5A, 2'b10, 0);
    chk("t4_pulse_count", 32'(to_cnt - to_base), 32'd1);

    // Reset while the output register holds a byte
    do_reset();
    q0.push_back({1'b1, 8'h55});
    drive();
    wait_valid("t5");
    chk("t5_held", 32'(utx_data), 32'h55);
    #3;
    rst_n = 1'b0;
    #1;
    chk("t5_valid_drop", 32'(utx_valid), 32'd0);
    chk("t5_grant_drop", 32'(grant), 32'd0);
    chk("t5_ready_drop", 32'({s0_ready, s1_ready}), 32'd0);
    q0.delete();
    drive();
    step();
    rst_n = 1'b1;
    q1.push_back({1'b1, 8'h66});
    drive();
    step();
    chk("t5_grant_s1", 32'(grant), 32'b10);
    expect_byte("t5_first", 8'h66, 2'b10, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
